rptr_generation: RTL and testbench

Read-side pointer controller for the RX elastic buffer, in the local (read) clock domain. Generates the binary/Gray read pointer and read address, decodes the synchronized Gray write pointer into an occupancy level, and flags empty and underflow. Gates reads until the buffer is pre-filled. Compensates clock drift by inserting SKP symbols: it re-reads an SKP at the head when occupancy is low. Companion to the write-side pointer generator, which deletes SKPs when occupancy is high.

---
 rtl/rptr_generation.sv | 133 +++++++++++++
 tb/tb_rptr_generation.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rptr_generation.sv
// rptr_generation: read-side pointer controller for the RX elastic buffer.
// Lives in the local (read) clock domain. It decodes the synchronized Gray
// write pointer into an occupancy level and gates reads until the buffer is
// pre-filled. It compensates clock drift by repeating an SKP at the head when
// occupancy runs low.
module rptr_generation #(
  parameter int PTR_WIDTH     = 4,
  parameter int ADDR_WIDTH    = 3,
  parameter int LOW_THRESHOLD = 2,
  parameter int START_LEVEL   = 4
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic                  LTSSM_rst,
  input  logic                  read_en,
  input  logic [PTR_WIDTH-1:0]  r_gray_wptr,
  input  logic                  skp_at_head,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic [PTR_WIDTH-1:0]  gray_rptr,
  output logic [PTR_WIDTH-1:0]  fill_level,
  output logic                  empty,
  output logic                  data_valid,
  output logic                  SKP_add_rqst,
  output logic                  skp_inserted,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH-1:0] LOW_LVL   = PTR_WIDTH'(LOW_THRESHOLD);
  localparam logic [PTR_WIDTH-1:0] START_LVL = PTR_WIDTH'(START_LEVEL);

  // FILL waits for pre-fill, RUN reads normally, HOLD has just repeated an SKP
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [PTR_WIDTH-1:0]   rptr_next;
  logic [PTR_WIDTH-1:0]   wptr;
  logic                   clear;
  logic                   low_level;
  logic                   dv_raw;
  logic                   ins_raw;
  logic                   uf_raw;

  // Either reset source clears the controller; they are deliberately identical
  assign clear = rx_rst | LTSSM_rst;

  // Gray to binary: each bit is the XOR of itself and every more significant bit
  always_comb begin
    wptr = '0;
    wptr[PTR_WIDTH-1] = r_gray_wptr[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      wptr[i] = wptr[i+1] ^ r_gray_wptr[i];
    end
  end

  // Occupancy wraps with the pointers, so plain modular subtraction is exact.
  // The write pointer arrives late through the synchronizer, so this never over-reports.
  assign fill_level = wptr - rptr;
  assign empty      = (fill_level == '0);
  assign low_level  = (fill_level < LOW_LVL);
  assign raddr      = rptr[ADDR_WIDTH-1:0];

  // Decide this cycle's read action and the next state/pointer
  always_comb begin
    state_next = state;
    rptr_next  = rptr;
    dv_raw     = 1'b0;
    ins_raw    = 1'b0;
    uf_raw     = 1'b0;
    case (state)
      FILL: begin
        if (fill_level >= START_LVL) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (read_en && empty) begin
          uf_raw     = 1'b1;
          state_next = FILL;
        end else if (read_en && low_level && skp_at_head) begin
          // Present the SKP but keep the pointer so the same SKP is read again
          dv_raw     = 1'b1;
          ins_raw    = 1'b1;
          state_next = HOLD;
        end else if (read_en) begin
          dv_raw    = 1'b1;
          rptr_next = rptr + 1'b1;
        end
      end
      HOLD: begin
        // The repeated SKP is always consumed here; it can never be repeated twice
        if (read_en && empty) begin
          uf_raw     = 1'b1;
          state_next = FILL;
        end else if (read_en) begin
          dv_raw     = 1'b1;
          rptr_next  = rptr + 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Status outputs are forced low while a clear is being applied
  always_comb begin
    data_valid   = dv_raw & ~clear;
    skp_inserted = ins_raw & ~clear;
    underflow    = uf_raw & ~clear;
    SKP_add_rqst = (state != FILL) && low_level && !clear;
  end

  // Register state, binary pointer and its Gray image together so they change on one edge
  always_ff @(posedge rx_clk) begin
    if (clear) begin
      state     <= FILL;
      rptr      <= '0;
      gray_rptr <= '0;
    end else begin
      state     <= state_next;
      rptr      <= rptr_next;
      gray_rptr <= rptr_next ^ (rptr_next >> 1);
    end
  end

endmodule

// File: tb/tb_rptr_generation.sv
// tb_rptr_generation: directed, table-driven bench for the read pointer controller.
module tb_rptr_generation;

  logic       rx_clk;
  logic       rx_rst;
  logic       LTSSM_rst;
  logic       read_en;
  logic [3:0] r_gray_wptr;
  logic       skp_at_head;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic [3:0] gray_rptr;
  logic [3:0] fill_level;
  logic       empty;
  logic       data_valid;
  logic       SKP_add_rqst;
  logic       skp_inserted;
  logic       underflow;

  int checks;
  int errors;

  rptr_generation #(
    .PTR_WIDTH(4),
    .ADDR_WIDTH(3),
    .LOW_THRESHOLD(2),
    .START_LEVEL(4)
  ) dut (
    .rx_clk(rx_clk),
    .rx_rst(rx_rst),
    .LTSSM_rst(LTSSM_rst),
    .read_en(read_en),
    .r_gray_wptr(r_gray_wptr),
    .skp_at_head(skp_at_head),
    .raddr(raddr),
    .rptr(rptr),
    .gray_rptr(gray_rptr),
    .fill_level(fill_level),
    .empty(empty),
    .data_valid(data_valid),
    .SKP_add_rqst(SKP_add_rqst),
    .skp_inserted(skp_inserted),
    .underflow(underflow)
  );

  // 10 ns read clock
  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       re;
    logic [3:0] wptr;
    logic       skp;
    logic       ltssm;
    logic [3:0] e_rptr;
    logic [3:0] e_fill;
    logic       e_dv;
    logic       e_ins;
    logic       e_uf;
    logic       e_rq;
    logic       e_empty;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic apply_stimulus(input logic re, input logic [3:0] w, input logic skp,
                                input logic rst, input logic ltssm);
    read_en     = re;
    r_gray_wptr = to_gray(w);
    skp_at_head = skp;
    rx_rst      = rst;
    LTSSM_rst   = ltssm;
  endtask

  task automatic check_output(input string name, input int idx, input logic [3:0] actual,
                              input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, actual, expected);
    end
  endtask

  // Scalar variant so one-bit outputs print cleanly
  task automatic check_bit(input string name, input int idx, input logic actual,
                           input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, actual, expected);
    end
  endtask

  logic [3:0] model_rptr;
  logic [3:0] prev_gray;

  initial begin
    checks = 0;
    errors = 0;

    // Fill, stream, no-insert at fill 5, drain, underflow, refill, insert, LTSSM clear in HOLD,
    // refill, insert, HOLD idle, HOLD consume
    //           re    w     skp   lt    rptr  fill  dv    ins   uf    rq    empty
    vecs[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd8, 1'b1, 1'b0, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd8, 1'b0, 1'b0, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 4'd8, 1'b0, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 4'd12, 1'b0, 1'b0, 4'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd12, 1'b0, 1'b0, 4'd8, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 4'd10, 1'b1, 1'b0, 4'd9, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 4'd10, 1'b1, 1'b1, 4'd9, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 4'd4, 1'b1, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[27] = '{1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 4'd4, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset with a read pending and a non-zero write pointer: outputs must stay quiet
    apply_stimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    @(posedge rx_clk);
    @(negedge rx_clk);
    check_output("reset_rptr", -1, rptr, 4'd0);
    check_output("reset_gray", -1, gray_rptr, 4'd0);
    check_output("reset_raddr", -1, {1'b0, raddr}, 4'd0);
    check_bit("reset_dv", -1, data_valid, 1'b0);
    check_bit("reset_ins", -1, skp_inserted, 1'b0);
    check_bit("reset_uf", -1, underflow, 1'b0);
    check_bit("reset_rq", -1, SKP_add_rqst, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    @(posedge rx_clk);
    @(negedge rx_clk);

    // Table: inputs are driven mid-cycle and outputs sampled before the next rising edge
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].re, vecs[i].wptr, vecs[i].skp, 1'b0, vecs[i].ltssm);
      #1;
      check_output("rptr", i, rptr, vecs[i].e_rptr);
      check_output("raddr", i, {1'b0, raddr}, {1'b0, vecs[i].e_rptr[2:0]});
      check_output("gray_rptr", i, gray_rptr, to_gray(vecs[i].e_rptr));
      check_output("fill_level", i, fill_level, vecs[i].e_fill);
      check_bit("empty", i, empty, vecs[i].e_empty);
      check_bit("data_valid", i, data_valid, vecs[i].e_dv);
      check_bit("skp_inserted", i, skp_inserted, vecs[i].e_ins);
      check_bit("underflow", i, underflow, vecs[i].e_uf);
      check_bit("SKP_add_rqst", i, SKP_add_rqst, vecs[i].e_rq);
      @(posedge rx_clk);
      @(negedge rx_clk);
    end

    // Wrap sequence: stream 20 symbols from rptr=4 with the writer four ahead
    model_rptr = 4'd4;
    prev_gray  = to_gray(model_rptr);
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, model_rptr + 4'd4, 1'b0, 1'b0, 1'b0);
      #1;
      check_output("wrap_rptr", 100 + k, rptr, model_rptr);
      check_output("wrap_raddr", 100 + k, {1'b0, raddr}, {1'b0, model_rptr[2:0]});
      check_output("wrap_gray", 100 + k, gray_rptr, to_gray(model_rptr));
      check_output("wrap_fill", 100 + k, fill_level, 4'd4);
      check_bit("wrap_dv", 100 + k, data_valid, 1'b1);
      if (k > 0) begin
        check_output("wrap_gray_onebit", 100 + k, 4'($countones(gray_rptr ^ prev_gray)), 4'd1);
      end
      prev_gray = gray_rptr;
      @(posedge rx_clk);
      @(negedge rx_clk);
      model_rptr = model_rptr + 4'd1;
    end

    // Pointer must have crossed 15 -> 0 and landed on 8
    check_output("wrap_final", 200, rptr, 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
